// File: rtl/relu_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : relu_frame_buffer
// Description : Streams signed elements in, applies optional ReLU (RELU_EN),
//               assembles a packed frame and hands it off via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_frame_buffer #(
    parameter int IN_WIDTH    = 4,
    parameter int IN_CHANNELS = 1,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                                in_data,
    input  logic                                                 in_last,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [IN_WIDTH*IN_WIDTH*IN_CHANNELS*DATA_WIDTH-1:0]  out_feature_map,
    output logic                                                 frame_err
);

    localparam int c_num_elems = IN_WIDTH * IN_WIDTH * IN_CHANNELS;
    localparam int c_idx_w     = (c_num_elems > 1) ? $clog2(c_num_elems) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_elems - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_idx_w-1:0]      r_idx;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_at_last;
    logic [DATA_WIDTH-1:0]   w_act;

    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == HOLD);
    assign frame_err = r_err;

    assign w_accept  = in_valid & in_ready;
    assign w_at_last = (r_idx == c_last_idx);

`ifdef RELU_EN
    assign w_act = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign w_act = in_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FILL:    if (w_accept && w_at_last) w_state_next = HOLD;
            HOLD:    if (out_ready)             w_state_next = FILL;
            default: w_state_next = FILL;
        endcase
    end

    // Frame boundaries come only from the count; in_last merely cross-checks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_idx <= w_at_last ? '0 : r_idx + 1'b1;
            if (in_last != w_at_last) begin
                r_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < c_num_elems; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] r_val;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_val <= '0;
                end else if (w_accept && (r_idx == c_idx_w'(gi))) begin
                    r_val <= w_act;
                end
            end

            assign out_feature_map[gi*DATA_WIDTH +: DATA_WIDTH] = r_val;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_relu_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_frame_buffer
// Description : Randomized self-checking bench with a frame-level reference
//               model; a second instance covers the multi-channel layout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_frame_buffer;

    localparam int DW  = 16;
    localparam int N   = 16;
    localparam int MW  = N * DW;
    localparam int BN  = 12;
    localparam int BMW = BN * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_last, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, frame_err;
    logic [MW-1:0] fmap;

    logic           b_rst, b_in_valid, b_in_last, b_out_ready;
    logic [DW-1:0]  b_in_data;
    logic           b_in_ready, b_out_valid, b_frame_err;
    logic [BMW-1:0] b_fmap;

    relu_frame_buffer #(.IN_WIDTH(4), .IN_CHANNELS(1), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_feature_map(fmap), .frame_err(frame_err)
    );

    relu_frame_buffer #(.IN_WIDTH(2), .IN_CHANNELS(3), .DATA_WIDTH(DW)) dut_ch (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_feature_map(b_fmap), .frame_err(b_frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_map [N];
    int            m_idx;
    bit            m_hold;
    bit            m_err;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] act(input logic [DW-1:0] v);
`ifdef RELU_EN
        return ($signed(v) < 0) ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [MW-1:0] model_map();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[i*DW +: DW] = m_map[i];
        return m;
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_hold = 0;
        m_err  = 0;
        for (int i = 0; i < N; i++) m_map[i] = '0;
    endtask

    task automatic check_all();
        check("in_ready",  in_ready,  !m_hold);
        check("out_valid", out_valid, m_hold);
        check("frame_err", frame_err, m_err);
        check("map",       fmap,      model_map());
    endtask

    // One clock: the model consumes the inputs seen at the edge, then the DUT is compared.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_hold) begin
            if (in_valid) begin
                m_map[m_idx] = act(in_data);
                if (in_last != (m_idx == N - 1)) m_err = 1;
                if (m_idx == N - 1) begin
                    m_idx  = 0;
                    m_hold = 1;
                end else begin
                    m_idx++;
                end
            end
        end else if (out_ready) begin
            m_hold = 0;
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        cycle();
    endtask

    logic [DW-1:0] neg_stored;
    int            guard;

    initial begin
        rst = 1; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
        b_rst = 1; b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_out_ready = 0;
        model_reset();
`ifdef RELU_EN
        neg_stored = 16'h0000;
`else
        neg_stored = 16'h8000;
`endif
        cycle();
        cycle();
        rst = 0;
        drive(0, '0, 0, 0);
        check("reset_in_ready", in_ready, 1'b1);

        // Basic frame 1..16
        for (int i = 0; i < N; i++) drive(1, DW'(i + 1), i == N - 1, 0);
        check("basic_valid",   out_valid, 1'b1);
        check("basic_slice0",  fmap[0 +: DW], 16'h0001);
        check("basic_slice15", fmap[15*DW +: DW], 16'h0010);
        drive(1, 16'h1234, 0, 0);
        check("basic_hold_ready", in_ready, 1'b0);
        drive(0, '0, 0, 1);
        check("basic_ready_after_pulse", in_ready, 1'b1);

        // ReLU pattern
        for (int i = 0; i < N; i++) drive(1, (i % 2) ? 16'h7FFF : 16'h8000, i == N - 1, 0);
        check("relu_slice0", fmap[0 +: DW], neg_stored);
        check("relu_slice1", fmap[DW +: DW], 16'h7FFF);
        drive(0, '0, 0, 1);

        // Backpressure with random gaps
        guard = 0;
        while (!m_hold && guard < 300) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom), m_idx == N - 1, 0);
            guard++;
        end
        check("bp_fill_timeout", m_hold, 1'b1);
        for (int i = 0; i < 10; i++)
            drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 0);
        drive(0, '0, 0, 1);
        check("bp_ready_after_pulse", in_ready, 1'b1);
        for (int i = 0; i < 5; i++) drive(1, DW'($urandom), 0, 0);

        // Early in_last
        rst = 1; drive(0, '0, 0, 0); rst = 0;
        for (int i = 0; i < N; i++) begin
            drive(1, DW'(i), i == 4, 0);
            if (i == 4) check("early_last_err", frame_err, 1'b1);
        end
        check("early_last_completes", out_valid, 1'b1);
        drive(0, '0, 0, 1);
        for (int i = 0; i < N; i++) drive(1, DW'(i), i == N - 1, 0);
        check("err_sticky", frame_err, 1'b1);

        // Missing in_last
        rst = 1; drive(0, '0, 0, 0); rst = 0;
        check("err_cleared", frame_err, 1'b0);
        for (int i = 0; i < N; i++) drive(1, DW'(i + 100), 0, 0);
        check("missing_last_err", frame_err, 1'b1);

        // Reset mid-frame with an accept in flight
        rst = 1; drive(0, '0, 0, 0); rst = 0;
        for (int i = 0; i < 7; i++) drive(1, DW'($urandom), 0, 0);
        rst = 1; drive(1, 16'h0F0F, 0, 0); rst = 0;
        check("midrst_map_zero", fmap, '0);
        check("midrst_out_valid", out_valid, 1'b0);
        for (int i = 0; i < N; i++) drive(1, DW'($urandom), i == N - 1, 0);
        check("midrst_followon_valid", out_valid, 1'b1);
        check("midrst_followon_err", frame_err, 1'b0);

        // Random soak
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 1)), DW'($urandom),
                  ($urandom_range(0, 7) != 0) ? (m_idx == N - 1) : (m_idx != N - 1),
                  1'($urandom_range(0, 1)));
        end
        rst = 0;

        // Multi-channel layout
        @(posedge clk); #1;
        b_rst = 0;
        @(posedge clk); #1;
        for (int v = 0; v < BN; v++) begin
            check("ch_in_ready", b_in_ready, 1'b1);
            b_in_valid = 1;
            b_in_data  = DW'(v);
            b_in_last  = (v == BN - 1);
            @(posedge clk); #1;
        end
        b_in_valid = 0;
        b_in_last  = 0;
        check("ch_out_valid", b_out_valid, 1'b1);
        check("ch_r1c0c2", b_fmap[8*DW +: DW], 16'd8);
        check("ch_err", b_frame_err, 1'b0);
        for (int v = 0; v < BN; v++) check("ch_slice", b_fmap[v*DW +: DW], DW'(v));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/relu_frame_buffer.md
# relu_frame_buffer

Streaming activation and frame-assembly stage directly upstream of the max-pooling stage. Accepts one convolution-output element per cycle over a valid/ready handshake, applies ReLU, and writes each result into a flat frame register laid out exactly as the pooling stage indexes its input. When a full IN_WIDTH×IN_WIDTH×IN_CHANNELS frame has been collected, it holds the frame stable and presents it with a valid/ready output handshake. The pooling stage's enable is driven from `out_valid & out_ready`.

## Interface
- IN_WIDTH, 4, spatial height/width of the square frame (elements)
- IN_CHANNELS, 1, channels per spatial position
- DATA_WIDTH, 16, bits per element; two's-complement signed on input
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  in_data holds an element
- in_ready  output  1  block can accept an element
- in_data  input  DATA_WIDTH  signed element
- in_last  input  1  marks the final element of a frame
- out_valid  output  1  out_feature_map holds a complete frame
- out_ready  input  1  consumer takes the frame
- out_feature_map  output  IN_WIDTH*IN_WIDTH*IN_CHANNELS*DATA_WIDTH  packed frame
- frame_err  output  1  sticky framing-error flag

## Operation
- N = IN_WIDTH*IN_WIDTH*IN_CHANNELS; element counter `idx` is $clog2(N) bits wide, minimum 1.
- Arrival order: channel fastest, then column, then row. Element `idx` = (row*IN_WIDTH+col)*IN_CHANNELS+c is stored in bits [idx*DATA_WIDTH +: DATA_WIDTH].
- Two states:
  - FILL: in_ready=1 and out_valid=0. An accept (`in_valid & in_ready`) writes the activated element at `idx` and increments `idx`. The accept with idx==N-1 resets `idx` to 0 and moves the block to HOLD.
  - HOLD: in_ready=0 and out_valid=1. out_feature_map is frozen. The handshake `out_ready` returns the block to FILL.
- Activation: an element with MSB=1 is stored as 0. Any other element is stored unchanged. No width change.
- Framing: frame_err is set and stays set until rst in either of two cases:
  - an accept has in_last=1 and idx≠N-1;
  - an accept has idx==N-1 and in_last=0.
- Framing errors do not alter the counting. Frame boundaries are always set by the count, never by in_last.
- Elements not yet overwritten in FILL keep their values from the previous frame. The map is only valid while out_valid=1.
- in_valid is ignored in HOLD. out_ready is ignored in FILL.

## Timing
- Reset values: state=FILL, idx=0, out_feature_map=0, frame_err=0, out_valid=0.
- in_ready and out_valid are pure decodes of the registered state. in_ready=1 from the first cycle after the reset edge.
- Throughput: one element per cycle in FILL.
- Latency: the accept of element N-1 at edge k gives out_valid=1 in the cycle after edge k.
- The out handshake at edge m gives in_ready=1 in the cycle after edge m. This is one bubble cycle per frame. The design does not overlap fill and hold.
- rst asserted mid-frame: the partial frame is discarded, all registers return to reset values, and an in-flight accept in the same cycle is dropped.
- rst takes priority over both handshakes in the same cycle.
- N=1: every accept goes straight to HOLD.

## Configuration
- RELU_EN defined: the ReLU clamp described above is applied.
- RELU_EN undefined: elements are stored unchanged, including negative values. All other behaviour and timing are identical. This mode is used when the upstream stage already applies its activation.

## Test plan
- Reset and basic frame (IN_WIDTH=4, IN_CHANNELS=1, DATA_WIDTH=16, RELU_EN):
  - Stimulus: after rst, stream 16 elements 0x0001..0x0010 back-to-back with in_last on the 16th.
  - Required: out_valid=1 one cycle after the 16th accept, slice i = i+1, frame_err=0, in_ready=0 while held.
- ReLU:
  - Stimulus: elements alternate 0x8000 and 0x7FFF.
  - Required: slices alternate 0x0000 and 0x7FFF.
  - Same stimulus with RELU_EN undefined: slices alternate 0x8000 and 0x7FFF.
- Backpressure and gaps:
  - Stimulus: in_valid toggled randomly; out_ready held 0 for 10 cycles after out_valid, then pulsed 1 cycle.
  - Required: map unchanged during the hold; in_ready=1 exactly one cycle after the pulse.
  - Second frame: slices written so far hold new data; unwritten slices still hold the first frame's values.
- Framing errors:
  - Stimulus: in_last on element 5.
  - Required: frame_err=1 the next cycle, the frame still completes after 16 accepts, frame_err stays 1 until rst.
  - Stimulus: in_last missing on element 16.
  - Required: frame_err=1.
- Reset mid-frame:
  - Stimulus: 7 accepts, then rst with in_valid=1 in the same cycle.
  - Required: idx=0, map all 0, out_valid=0.
  - Follow-on: a fresh 16-element frame completes normally.
- Channels (IN_WIDTH=2, IN_CHANNELS=3):
  - Stimulus: stream 12 values 0..11.
  - Required: the (row 1, col 0, c 2) value 8 lands in bits [8*16 +: 16].
